// File: rtl/lsu_pkg.sv
// Shared types and helpers for the MEM-stage load/store unit.
package lsu_pkg;

  typedef enum logic [2:0] {
    MEM_B  = 3'd0,
    MEM_H  = 3'd1,
    MEM_W  = 3'd2,
    MEM_BU = 3'd4,
    MEM_HU = 3'd5
  } mem_funct3_e;

  typedef enum logic {
    LSU_IDLE,
    LSU_SECOND
  } lsu_state_e;

  // Access size in bytes from funct3[1:0]; the illegal encoding 11 is screened by the caller.
  function automatic logic [2:0] size_bytes(input logic [1:0] sz);
    case (sz)
      2'b00:   size_bytes = 3'd1;
      2'b01:   size_bytes = 3'd2;
      default: size_bytes = 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: byte-enable mask over two words, store data lane shift,
// load data realignment and sign/zero extension.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  offset_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rdata_lo_i,
  input  logic [31:0] rdata_hi_i,
  output logic [7:0]  mask8_o,
  output logic [31:0] wdata_lo_o,
  output logic [31:0] wdata_hi_o,
  output logic [31:0] load_data_o
);

  logic [2:0]  n;
  logic [63:0] w64;
  logic [31:0] shifted;

  always_comb begin
    n       = size_bytes(funct3_i[1:0]);
    mask8_o = ((8'd1 << n) - 8'd1) << offset_i;
    w64     = {32'b0, wdata_i} << {offset_i, 3'b000};
    // A split load sees {high word, low word}; a single access just sees the word twice.
    shifted = 32'({rdata_hi_i, rdata_lo_i} >> {offset_i, 3'b000});
    case (funct3_i[1:0])
      2'b00:   load_data_o = {{24{~funct3_i[2] & shifted[7]}}, shifted[7:0]};
      2'b01:   load_data_o = {{16{~funct3_i[2] & shifted[15]}}, shifted[15:0]};
      default: load_data_o = shifted;
    endcase
  end

  assign wdata_lo_o = w64[31:0];
  assign wdata_hi_o = w64[63:32];

endmodule

// File: rtl/load_store_unit.sv
// MEM-stage load/store unit: byte-addressed requests to word accesses with byte enables,
// splitting word-crossing accesses into two back-to-back cycles while stalling the pipeline.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter bit MISALIGN_EN = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  input  logic            req_we,
  input  logic [2:0]      req_funct3,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_wdata,
  output logic            stall,
  output logic            err,
  output logic [XLEN-1:0] load_data,
  output logic [15:0]     split_cnt,
  output logic            mem_valid,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  output logic [3:0]      mem_byte_enable,
  input  logic [XLEN-1:0] mem_rdata
);

  lsu_state_e  state_q, state_d;
  logic [31:0] hold_lo_q, hold_lo_d;
  logic [15:0] split_cnt_q, split_cnt_d;

  logic [7:0]  mask8;
  logic [31:0] wdata_lo, wdata_hi;
  logic        illegal, is_split;
  logic [31:0] word_addr;

  lsu_align u_align (
    .funct3_i    (req_funct3),
    .offset_i    (req_addr[1:0]),
    .wdata_i     (req_wdata),
    .rdata_lo_i  ((state_q == LSU_SECOND) ? hold_lo_q : mem_rdata),
    .rdata_hi_i  (mem_rdata),
    .mask8_o     (mask8),
    .wdata_lo_o  (wdata_lo),
    .wdata_hi_o  (wdata_hi),
    .load_data_o (load_data)
  );

  assign illegal   = (req_funct3 == 3'b011) || (req_funct3[2:1] == 2'b11) || (req_we && req_funct3[2]);
  assign is_split  = |mask8[7:4];
  assign word_addr = {req_addr[31:2], 2'b00};
  assign err       = ~rst & req_valid & (illegal | (is_split & ~MISALIGN_EN));
  // A dropped req_valid in SECOND is a flush: it falls out here as mem_valid=0.
  assign mem_valid = ~rst & req_valid & ~err;
  assign mem_we    = req_we & mem_valid;
  assign split_cnt = split_cnt_q;

  always_comb begin
    state_d         = state_q;
    hold_lo_d       = hold_lo_q;
    split_cnt_d     = split_cnt_q;
    stall           = 1'b0;
    mem_addr        = word_addr;
    mem_wdata       = wdata_lo;
    mem_byte_enable = mask8[3:0];
    case (state_q)
      LSU_IDLE: begin
        if (mem_valid && is_split) begin
          stall     = 1'b1;
          hold_lo_d = mem_rdata;
          state_d   = LSU_SECOND;
        end
      end
      LSU_SECOND: begin
        state_d         = LSU_IDLE;
        mem_addr        = word_addr + 32'd4;
        mem_wdata       = wdata_hi;
        mem_byte_enable = mask8[7:4];
        if (mem_valid && split_cnt_q != 16'hFFFF) split_cnt_d = split_cnt_q + 16'd1;
      end
      default: state_d = LSU_IDLE;
    endcase
    if (!mem_valid) mem_byte_enable = 4'b0000;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= LSU_IDLE;
      hold_lo_q   <= 32'b0;
      split_cnt_q <= 16'b0;
    end else begin
      state_q     <= state_d;
      hold_lo_q   <= hold_lo_d;
      split_cnt_q <= split_cnt_d;
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench: byte-level memory reference model checking a split-capable LSU and a non-splitting twin.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_we = 1'b0;
  logic [2:0]  req_funct3 = 3'b010;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;

  logic        stall, err, mem_valid, mem_we;
  logic [31:0] load_data, mem_addr, mem_wdata, mem_rdata;
  logic [15:0] split_cnt;
  logic [3:0]  mem_byte_enable;

  logic        d0_stall, d0_err, d0_mem_valid, d0_mem_we;
  logic [31:0] d0_load_data, d0_mem_addr, d0_mem_wdata, d0_mem_rdata;
  logic [15:0] d0_split_cnt;
  logic [3:0]  d0_mem_byte_enable;

  logic [31:0] mem [64];
  logic [7:0]  ref_mem [256];
  int          ref_splits;
  int          checks = 0;
  int          passed = 0;
  logic [3:0]  be0, be1;
  logic [31:0] a0, a1;

  always #5 clk = ~clk;

  load_store_unit #(.XLEN(32), .MISALIGN_EN(1'b1)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_we(req_we), .req_funct3(req_funct3),
    .req_addr(req_addr), .req_wdata(req_wdata), .stall(stall), .err(err), .load_data(load_data),
    .split_cnt(split_cnt), .mem_valid(mem_valid), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_byte_enable(mem_byte_enable), .mem_rdata(mem_rdata)
  );

  load_store_unit #(.XLEN(32), .MISALIGN_EN(1'b0)) dut0 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_we(req_we), .req_funct3(req_funct3),
    .req_addr(req_addr), .req_wdata(req_wdata), .stall(d0_stall), .err(d0_err),
    .load_data(d0_load_data), .split_cnt(d0_split_cnt), .mem_valid(d0_mem_valid),
    .mem_we(d0_mem_we), .mem_addr(d0_mem_addr), .mem_wdata(d0_mem_wdata),
    .mem_byte_enable(d0_mem_byte_enable), .mem_rdata(d0_mem_rdata)
  );

  // Data memory: 64 words, combinational read, byte-enabled write; only the main DUT writes.
  assign mem_rdata    = mem[mem_addr[7:2]];
  assign d0_mem_rdata = mem[d0_mem_addr[7:2]];

  always @(posedge clk) begin
    if (mem_valid && mem_we)
      for (int b = 0; b < 4; b++)
        if (mem_byte_enable[b]) mem[mem_addr[7:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  function automatic int nbytes(input logic [2:0] f3);
    return (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
  endfunction

  function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] addr);
    logic [31:0] v;
    int n;
    n = nbytes(f3);
    v = 32'h0;
    for (int i = 0; i < n; i++) v[8*i +: 8] = ref_mem[(addr + i) & 32'hFF];
    if (!f3[2] && n == 1 && v[7])  v = v | 32'hFFFFFF00;
    if (!f3[2] && n == 2 && v[15]) v = v | 32'hFFFF0000;
    return v;
  endfunction

  // One legal request held until stall drops; checks stall length, load data and split count.
  task automatic run_op(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wd, input string tag);
    int n, stalls;
    bit split, got;
    logic [31:0] ld;
    n      = nbytes(f3);
    split  = (int'(addr[1:0]) + n) > 4;
    stalls = 0;
    got    = 0;
    ld     = 32'h0;
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
    for (int c = 0; c < 4 && !got; c++) begin
      @(negedge clk);
      if (c == 0) begin be0 = mem_byte_enable; a0 = mem_addr; end
      else        begin be1 = mem_byte_enable; a1 = mem_addr; end
      if (!stall) begin ld = load_data; got = 1; end
      else stalls++;
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
    check({tag, "_done"}, 32'(got), 32'd1);
    check({tag, "_stalls"}, stalls, 32'(split));
    if (!we) check({tag, "_load"}, ld, ref_load(f3, addr));
    else for (int i = 0; i < n; i++) ref_mem[(addr + i) & 32'hFF] = wd[8*i +: 8];
    if (split && ref_splits < 16'hFFFF) ref_splits++;
    check({tag, "_split_cnt"}, {16'h0, split_cnt}, ref_splits);
  endtask

  initial begin
    logic [2:0] f3;
    logic       we;
    for (int i = 0; i < 64; i++) mem[i] = 32'h0;
    for (int i = 0; i < 256; i++) ref_mem[i] = 8'h0;
    ref_splits = 0;

    // Reset holds outputs quiet even with a request presented.
    req_valid = 1'b1; req_addr = 32'h0E;
    @(negedge clk);
    check("rst_stall", {31'h0, stall}, 32'h0);
    check("rst_err", {31'h0, err}, 32'h0);
    check("rst_mem_valid", {31'h0, mem_valid}, 32'h0);
    check("rst_split_cnt", {16'h0, split_cnt}, 32'h0);
    req_valid = 1'b0;
    @(posedge clk); #1 rst = 1'b0;

    run_op(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, "sw_10");
    check("sw_10_be", {28'h0, be0}, 32'hF);
    run_op(1'b0, 3'b010, 32'h10, 32'h0, "lw_10");
    check("lw_10_be", {28'h0, be0}, 32'hF);
    check("lw_10_val", ref_load(3'b010, 32'h10), 32'hDEADBEEF);

    run_op(1'b1, 3'b000, 32'h13, 32'h80, "sb_13");
    check("sb_13_be", {28'h0, be0}, 32'h8);
    run_op(1'b0, 3'b000, 32'h13, 32'h0, "lb_13");
    check("lb_13_val", ref_load(3'b000, 32'h13), 32'hFFFFFF80);
    run_op(1'b0, 3'b100, 32'h13, 32'h0, "lbu_13");
    check("lbu_13_val", ref_load(3'b100, 32'h13), 32'h00000080);

    run_op(1'b1, 3'b010, 32'h0E, 32'h11223344, "sw_0e");
    check("sw_0e_be_lo", {28'h0, be0}, 32'hC);
    check("sw_0e_addr_lo", a0, 32'h0C);
    check("sw_0e_be_hi", {28'h0, be1}, 32'h3);
    check("sw_0e_addr_hi", a1, 32'h10);
    run_op(1'b0, 3'b010, 32'h0E, 32'h0, "lw_0e");
    check("lw_0e_cnt2", {16'h0, split_cnt}, 32'd2);

    run_op(1'b1, 3'b010, 32'h0C, 32'hAB000000, "sw_0c");
    run_op(1'b1, 3'b010, 32'h10, 32'h000000CD, "sw_10b");
    run_op(1'b0, 3'b001, 32'h0F, 32'h0, "lh_0f");
    check("lh_0f_val", ref_load(3'b001, 32'h0F), 32'hFFFFCDAB);

    // Word-crossing store at the top of the address space wraps to word 0.
    run_op(1'b1, 3'b010, 32'hFFFFFFFE, 32'hA5C3E1F0, "sw_wrap");
    check("sw_wrap_addr_lo", a0, 32'hFFFFFFFC);
    check("sw_wrap_addr_hi", a1, 32'h00000000);
    run_op(1'b0, 3'b010, 32'hFFFFFFFE, 32'h0, "lw_wrap");

    // Error cases, sampled and withdrawn before the clock edge.
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h01;
    @(negedge clk);
    check("nomis_err", {31'h0, d0_err}, 32'h1);
    check("nomis_mem_valid", {31'h0, d0_mem_valid}, 32'h0);
    check("nomis_stall", {31'h0, d0_stall}, 32'h0);
    req_funct3 = 3'b011; req_addr = 32'h10; #1;
    check("f3_011_err", {31'h0, err}, 32'h1);
    check("f3_011_mem_valid", {31'h0, mem_valid}, 32'h0);
    req_we = 1'b1; req_funct3 = 3'b100; #1;
    check("sbu_err", {31'h0, err}, 32'h1);
    req_we = 1'b0; req_funct3 = 3'b010; #1;
    check("nomis_aligned_err", {31'h0, d0_err}, 32'h0);
    req_valid = 1'b0;
    @(posedge clk); #1;

    // Flush: req_valid dropped in the second cycle of a split load.
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h0E;
    @(negedge clk);
    check("flush_first_stall", {31'h0, stall}, 32'h1);
    @(posedge clk); #1 req_valid = 1'b0;
    @(negedge clk);
    check("flush_mem_valid", {31'h0, mem_valid}, 32'h0);
    check("flush_stall", {31'h0, stall}, 32'h0);
    @(posedge clk); #1;
    check("flush_split_cnt", {16'h0, split_cnt}, ref_splits);
    run_op(1'b0, 3'b010, 32'h0E, 32'h0, "after_flush");

    // Reset asserted while in the second cycle of a split.
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h0E;
    @(negedge clk);
    @(posedge clk); #1 rst = 1'b1;
    #1;
    check("midrst_stall", {31'h0, stall}, 32'h0);
    check("midrst_split_cnt", {16'h0, split_cnt}, 32'h0);
    req_valid = 1'b0;
    @(posedge clk); #1 rst = 1'b0;
    ref_splits = 0;
    run_op(1'b0, 3'b010, 32'h0E, 32'h0, "after_rst");

    // Random legal traffic against the byte-level model.
    for (int k = 0; k < 60; k++) begin
      we = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 4))
        0: f3 = 3'b000;
        1: f3 = 3'b001;
        2: f3 = 3'b010;
        3: f3 = 3'b100;
        default: f3 = 3'b101;
      endcase
      if (we) f3[2] = 1'b0;
      run_op(we, f3, 32'($urandom_range(0, 255)), $urandom, "rand");
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
